// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the program RAM and hands bytes to the decoder.
// Optional FETCH_TRACE_EN adds a saturating accepted-fetch counter (fetch_count).
module fetch_unit #(
  parameter int unsigned          ADDR_W      = 4,
  parameter int unsigned          DATA_W      = 8,
  parameter logic [DATA_W-1:0]    HALT_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted
`ifdef FETCH_TRACE_EN
  ,
  output logic [7:0]        fetch_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              capture;
  logic              is_halt;

  assign ram_addr = pc;
  assign is_halt  = (ram_data == HALT_OPCODE);
  // A capture happens when fetching, or when the held byte is taken and fetching continues.
  assign capture  = run && ((state == FETCH) || ((state == HOLD) && instr_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (jmp_valid) begin
      // Jump discards any pending instruction, even one being accepted this cycle.
      pc          <= jmp_addr;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      state       <= run ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE:    if (run) state <= FETCH;
        FETCH:   if (!run) state <= IDLE;
        HOLD: begin
          if (instr_ready && !run) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
      if (capture) begin
        instr    <= ram_data;
        instr_pc <= pc;
        if (is_halt) begin
          instr_valid <= 1'b0;
          halted      <= 1'b1;
          state       <= HALT;
        end else begin
          instr_valid <= 1'b1;
          pc          <= pc + ADDR_W'(1);
          state       <= HOLD;
        end
      end
    end
  end

`ifdef FETCH_TRACE_EN
  // Counts accepted handshakes, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 8'h00;
    end else if (instr_valid && instr_ready && !jmp_valid && (fetch_count != 8'hFF)) begin
      fetch_count <= fetch_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected (instr, instr_pc), a monitor pops on each accepted handshake.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst, run, jmp_valid, instr_ready;
  logic [3:0] jmp_addr, ram_addr, instr_pc;
  logic [7:0] ram_data, instr;
  logic       instr_valid, halted;
`ifdef FETCH_TRACE_EN
  logic [7:0] fetch_count;
`endif

  logic [7:0]  ram [16];
  logic [11:0] sb [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  assign ram_data = ram[ram_addr];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .jmp_valid  (jmp_valid),
    .jmp_addr   (jmp_addr),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .halted     (halted)
`ifdef FETCH_TRACE_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] a);
    sb.push_back({d, a});
  endtask

  // Monitor: every accepted handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !jmp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_accept", {20'h0, instr, instr_pc}, 32'hFFFF_FFFF);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        chk("sb_instr", 32'(instr), 32'(e[11:4]));
        chk("sb_instr_pc", 32'(instr_pc), 32'(e[3:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
    rst = 1'b1; run = 1'b0; jmp_valid = 1'b0; jmp_addr = 4'd0; instr_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_instr_pc", 32'(instr_pc), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
`ifdef FETCH_TRACE_EN
    chk("rst_fetch_count", 32'(fetch_count), 32'h0);
`endif

    // Sequential fetch with a 3-cycle decoder stall on 8'h22.
    push(8'h11, 4'd0); push(8'h22, 4'd1); push(8'h33, 4'd2); push(8'h44, 4'd3);
    run = 1'b1;
    cyc();
    chk("lat_edge1_valid", 32'(instr_valid), 32'h0);
    cyc();
    chk("lat_edge2_valid", 32'(instr_valid), 32'h1);
    chk("lat_edge2_instr", 32'(instr), 32'h11);
    cyc();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_instr", 32'(instr), 32'h22);
      chk("hold_instr_pc", 32'(instr_pc), 32'h1);
      chk("hold_valid", 32'(instr_valid), 32'h1);
      chk("hold_pc", 32'(ram_addr), 32'h2);
    end
    instr_ready = 1'b1;
    cyc();
    chk("release_instr", 32'(instr), 32'h33);
    chk("release_instr_pc", 32'(instr_pc), 32'h2);
    cyc();
    run = 1'b0;
    cyc();
    chk("stop_valid", 32'(instr_valid), 32'h0);
    chk("stop_pc", 32'(ram_addr), 32'h4);

    // Jump to 15 and wrap to 0.
    ram[15] = 8'h5A; ram[0] = 8'h01;
    push(8'h5A, 4'd15); push(8'h01, 4'd0);
    jmp_valid = 1'b1; jmp_addr = 4'd15; run = 1'b1;
    cyc();
    jmp_valid = 1'b0;
    chk("jmp15_pc", 32'(ram_addr), 32'hF);
    chk("jmp15_valid", 32'(instr_valid), 32'h0);
    cyc();
    chk("wrap_instr_a", 32'(instr), 32'h5A);
    cyc();
    chk("wrap_instr_b", 32'(instr), 32'h01);
    chk("wrap_instr_pc_b", 32'(instr_pc), 32'h0);
    run = 1'b0;
    cyc();
    chk("wrap_stop_valid", 32'(instr_valid), 32'h0);

    // Halt opcode at address 2, then escape with a jump to 4.
    ram[2] = 8'hFF; ram[4] = 8'h77;
    push(8'h22, 4'd1);
    jmp_valid = 1'b1; jmp_addr = 4'd1; run = 1'b1;
    cyc();
    jmp_valid = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("halt_halted", 32'(halted), 32'h1);
      chk("halt_valid", 32'(instr_valid), 32'h0);
      chk("halt_pc", 32'(ram_addr), 32'h2);
      cyc();
    end
    jmp_valid = 1'b1; jmp_addr = 4'd4;
    cyc();
    jmp_valid = 1'b0;
    chk("unhalt_halted", 32'(halted), 32'h0);
    chk("unhalt_pc", 32'(ram_addr), 32'h4);
    cyc();
    chk("unhalt_instr", 32'(instr), 32'h77);
    chk("unhalt_instr_pc", 32'(instr_pc), 32'h4);
    chk("unhalt_valid", 32'(instr_valid), 32'h1);

    // Jump to 9 while the pending 8'h77 is being offered with ready high: it is discarded.
    ram[9] = 8'h99;
    jmp_valid = 1'b1; jmp_addr = 4'd9;
    cyc();
    jmp_valid = 1'b0;
    chk("jmpdrop_valid", 32'(instr_valid), 32'h0);
    chk("jmpdrop_pc", 32'(ram_addr), 32'h9);
    instr_ready = 1'b0;
    cyc();
    chk("jmpdrop_instr", 32'(instr), 32'h99);
    chk("jmpdrop_instr_pc", 32'(instr_pc), 32'h9);

    // Reset while holding a valid instruction.
    rst = 1'b1; run = 1'b0;
    cyc();
    rst = 1'b0;
    chk("midrst_instr", 32'(instr), 32'h0);
    chk("midrst_instr_pc", 32'(instr_pc), 32'h0);
    chk("midrst_valid", 32'(instr_valid), 32'h0);
    chk("midrst_halted", 32'(halted), 32'h0);
    chk("midrst_pc", 32'(ram_addr), 32'h0);
    cyc();
    chk("midrst_idle_valid", 32'(instr_valid), 32'h0);

    // 300 back-to-back accepted fetches.
    for (int i = 0; i < 16; i++) ram[i] = 8'h10;
    for (int i = 0; i < 300; i++) push(8'h10, 4'(i));
    instr_ready = 1'b1; run = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < 299; i++) cyc();
    run = 1'b0;
    cyc();
    chk("bulk_valid", 32'(instr_valid), 32'h0);
    chk("bulk_pc", 32'(ram_addr), 32'(300 % 16));
`ifdef FETCH_TRACE_EN
    chk("bulk_fetch_count", 32'(fetch_count), 32'hFF);
`endif
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
